tx_funcmod: RTL and testbench

UART transmitter, the send-side counterpart to rx_funcmod. It serialises one byte per call using the same frame: start bit, 8 data bits LSB first, parity bit, stop bit. Timing is 115200 baud from a 50 MHz clock (434 clocks per bit). It is driven by the codebase's iCall/oDone call handshake, normally from a control FSM or a FIFO reader.

---
 rtl/tx_funcmod.sv | 111 +++++++++++
 tb/tb_tx_funcmod.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tx_funcmod.sv
// UART transmitter: start bit, 8 data bits LSB first, parity, stop bit.
// Advances only while iCall is high; oDone pulses one clock after the stop bit.
module tx_funcmod #(
  parameter logic [8:0] BPS115K2   = 9'd434,
  parameter logic       PARITY_ODD = 1'b0
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iCall,
  input  logic [7:0] iData,
  output logic       oDone,
  output logic       TXD
);

  typedef enum logic [3:0] {
    LOAD   = 4'd0,
    START  = 4'd1,
    BIT0   = 4'd2,
    BIT1   = 4'd3,
    BIT2   = 4'd4,
    BIT3   = 4'd5,
    BIT4   = 4'd6,
    BIT5   = 4'd7,
    BIT6   = 4'd8,
    BIT7   = 4'd9,
    PARITY = 4'd10,
    STOP   = 4'd11,
    DONE   = 4'd12,
    CLEAR  = 4'd13
  } stepT;

  stepT       i, iNext;
  logic [8:0] C1, C1Next;
  logic [7:0] D1, D1Next;
  logic       P, PNext;
  logic       isDone, isDoneNext;
  logic       rTXD, rTXDNext;
  logic       lastTick;

  assign lastTick = (C1 == BPS115K2 - 9'd1);

  // Every register, including the line, freezes while iCall is low.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      i      <= LOAD;
      C1     <= '0;
      D1     <= '0;
      P      <= 1'b0;
      isDone <= 1'b0;
      rTXD   <= 1'b1;
    end else if (iCall) begin
      i      <= iNext;
      C1     <= C1Next;
      D1     <= D1Next;
      P      <= PNext;
      isDone <= isDoneNext;
      rTXD   <= rTXDNext;
    end
  end

  always_comb begin
    iNext      = i;
    C1Next     = C1;
    D1Next     = D1;
    PNext      = P;
    isDoneNext = isDone;
    rTXDNext   = rTXD;
    case (i)
      LOAD: begin
        D1Next   = iData;
        PNext    = (^iData) ^ PARITY_ODD;
        rTXDNext = 1'b0;
        C1Next   = '0;
        iNext    = START;
      end
      START, BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7, PARITY, STOP: begin
        if (lastTick) begin
          C1Next = '0;
          iNext  = stepT'(4'(i + 4'd1));
          // Level for the bit that starts once the current one ends.
          case (i)
            START:   rTXDNext = D1[0];
            BIT7:    rTXDNext = P;
            PARITY:  rTXDNext = 1'b1;
            STOP:    rTXDNext = 1'b1;
            default: rTXDNext = D1[3'(i - 4'd1)];
          endcase
        end else begin
          C1Next = C1 + 9'd1;
        end
      end
      DONE: begin
        isDoneNext = 1'b1;
        iNext      = CLEAR;
      end
      CLEAR: begin
        isDoneNext = 1'b0;
        iNext      = LOAD;
      end
      default: begin
        iNext      = LOAD;
        rTXDNext   = 1'b1;
        isDoneNext = 1'b0;
      end
    endcase
  end

  assign oDone = isDone;
  assign TXD   = rTXD;

endmodule

// File: tb/tb_tx_funcmod.sv
// Bench for tx_funcmod: even- and odd-parity instances, cycle-level line model,
// frame scoreboard, stall and mid-frame reset sequences.
module tb_tx_funcmod;

  localparam int BIT = 434;
  localparam int END_E = 11 * BIT + 2;  // clock after the oDone pulse

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       iCall0 = 1'b0, iCall1 = 1'b0;
  logic [7:0] iData0 = '0, iData1 = '0;
  logic       oDone0, TXD0, oDone1, TXD1;

  int checks = 0;
  int errors = 0;
  logic [10:0] sbq[$];

  typedef struct {
    logic [7:0] d;
    bit         odd;
    logic       par;
  } vecT;
  vecT vecs[8];

  tx_funcmod #(.BPS115K2(9'd434), .PARITY_ODD(1'b0)) dutEven (
    .CLOCK(CLOCK), .RESET(RESET), .iCall(iCall0), .iData(iData0),
    .oDone(oDone0), .TXD(TXD0));

  tx_funcmod #(.BPS115K2(9'd434), .PARITY_ODD(1'b1)) dutOdd (
    .CLOCK(CLOCK), .RESET(RESET), .iCall(iCall1), .iData(iData1),
    .oDone(oDone1), .TXD(TXD1));

  always #10 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit odd, input logic c, input logic [7:0] d);
    if (odd) begin iCall1 = c; iData1 = d; end
    else     begin iCall0 = c; iData0 = d; end
  endtask

  // s/L: drop iCall for L clocks starting at cycle s; abortAt>0 asserts RESET at that cycle.
  task automatic sendFrame(input logic [7:0] d, input bit odd, input logic par,
                           input int s, input int L, input int abortAt);
    logic [10:0] expF, actF, popped;
    logic txd, dn, exTxd, exDone;
    int waveErr, firstBad, doneCnt, e, frozen;
    expF = {1'b1, par, d, 1'b0};
    sbq.push_back(expF);
    actF = '0; waveErr = 0; firstBad = -1; doneCnt = 0;
    @(negedge CLOCK); drive(odd, 1'b1, d);
    @(posedge CLOCK); #1;
    drive(odd, 1'b1, ~d);  // must not affect the frame in flight
    for (int t = 0; ; t++) begin
      @(negedge CLOCK);
      if (abortAt > 0 && t == abortAt) begin
        drive(odd, 1'b0, d);
        RESET = 1'b0;
        #1;
        chk("abortTXD", {31'd0, odd ? TXD1 : TXD0}, 32'd1);
        chk("abortDone", {31'd0, odd ? oDone1 : oDone0}, 32'd0);
        popped = sbq.pop_front();
        return;
      end
      frozen = (t <= s) ? 0 : ((t - s) < L ? (t - s) : L);
      e = t - frozen;
      txd = odd ? TXD1 : TXD0;
      dn  = odd ? oDone1 : oDone0;
      exTxd  = (e < 11 * BIT) ? expF[e / BIT] : 1'b1;
      exDone = (e == 11 * BIT + 1);
      if (txd !== exTxd || dn !== exDone) begin
        waveErr++;
        if (firstBad < 0) firstBad = t;
      end
      doneCnt += (dn === 1'b1) ? 1 : 0;
      if (e < 11 * BIT && (e % BIT) == BIT / 2) actF[e / BIT] = txd;
      if (L > 0 && t == s) drive(odd, 1'b0, ~d);
      if (L > 0 && t == s + L) drive(odd, 1'b1, ~d);
      if (e == END_E) begin
        drive(odd, 1'b0, ~d);
        break;
      end
    end
    if (waveErr != 0) $display("FAIL wave: byte %02h first bad cycle %0d, %0d bad cycles, expected 0", d, firstBad, waveErr);
    checks++; if (waveErr != 0) errors++;
    chk("doneCount", doneCnt, 1);
    popped = sbq.pop_front();
    chk("frame", {21'd0, actF}, {21'd0, popped});
    chk("parity", {31'd0, actF[9]}, {31'd0, par});
    repeat (3) @(negedge CLOCK);
    chk("idleTXD", {31'd0, odd ? TXD1 : TXD0}, 32'd1);
    chk("idleDone", {31'd0, odd ? oDone1 : oDone0}, 32'd0);
  endtask

  initial begin
    int idleBad;
    vecs[0] = '{8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b1};
    vecs[2] = '{8'h07, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'hA3, 1'b0, 1'b0};
    vecs[6] = '{8'hA3, 1'b1, 1'b1};
    vecs[7] = '{8'h01, 1'b0, 1'b1};

    repeat (3) @(negedge CLOCK);
    chk("rstTXD0", {31'd0, TXD0}, 32'd1);
    chk("rstDone0", {31'd0, oDone0}, 32'd0);
    chk("rstTXD1", {31'd0, TXD1}, 32'd1);
    chk("rstDone1", {31'd0, oDone1}, 32'd0);
    RESET = 1'b1;

    idleBad = 0;
    repeat (2000) begin
      @(negedge CLOCK);
      if (TXD0 !== 1'b1 || oDone0 !== 1'b0 || TXD1 !== 1'b1 || oDone1 !== 1'b0) idleBad++;
    end
    chk("idle2000", idleBad, 0);

    foreach (vecs[n]) sendFrame(vecs[n].d, vecs[n].odd, vecs[n].par, 0, 0, 0);

    // Stall 100 clocks into data bit 3 (frame bit 4) of 8'hF0.
    sendFrame(8'hF0, 1'b0, 1'b0, 4 * BIT + 100, 100, 0);

    // Reset mid data bit 5, then a fresh frame.
    sendFrame(8'h3C, 1'b0, 1'b0, 0, 0, 6 * BIT + BIT / 2);
    repeat (2) @(negedge CLOCK);
    chk("heldTXD", {31'd0, TXD0}, 32'd1);
    RESET = 1'b1;
    sendFrame(8'h3C, 1'b0, 1'b0, 0, 0, 0);

    chk("sbEmpty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
